// File: rtl/fft_frame_sequencer.sv
// Frame scheduler for the 64-point in-place radix-2 DIF FFT core.
// Sequences load, compute stages and unload; the next frame's load overlaps the current unload.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for the first sample of a frame
//  LOAD    | accepting samples 1..N-1 of the frame into the core
//  COMPUTE | core runs its butterfly stages, one advance per cycle
//  UNLOAD  | streaming results to the sink, optionally loading next frame
module fft_frame_sequencer #(
   parameter int N_POINTS     = 64,
   parameter int CNT_W        = 6,
   parameter int N_STAGES     = 6,
   parameter int STAGE_CYCLES = 32,
   parameter int FRAME_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   flush,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_last,
   output logic                   core_start,
   output logic                   core_valid,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int COMP_CYCLES = N_STAGES * STAGE_CYCLES;
   localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(N_POINTS - 1);
   localparam logic [7:0]       COMP_LAST = 8'(COMP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       samp_q, samp_d;
   logic [7:0]             comp_q, comp_d;
   logic                   ovl_q, ovl_d;
   logic                   rst_done_q;
   logic [FRAME_CNT_W-1:0] frame_q, frame_d;
   logic                   advance;

   always_comb begin
      state_d    = state_q;
      samp_d     = samp_q;
      comp_d     = comp_q;
      ovl_d      = ovl_q;
      frame_d    = frame_q;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_last     = 1'b0;
      core_start = 1'b0;
      core_valid = 1'b0;
      advance    = 1'b0;

      // Nothing is decoded until the first cycle after reset release has passed.
      if (rst_done_q) begin
         case (state_q)
            IDLE: begin
               s_ready = 1'b1;
               if (s_valid) begin
                  core_start = 1'b1;
                  core_valid = 1'b1;
                  samp_d     = CNT_W'(1);
                  state_d    = LOAD;
               end
            end

            LOAD: begin
               s_ready    = 1'b1;
               core_valid = s_valid;
               if (s_valid) begin
                  if (samp_q == SAMP_LAST) begin
                     samp_d  = '0;
                     comp_d  = '0;
                     state_d = COMPUTE;
                  end else begin
                     samp_d = samp_q + CNT_W'(1);
                  end
               end
            end

            COMPUTE: begin
               core_valid = 1'b1;
               if (comp_q == COMP_LAST) begin
                  comp_d  = '0;
                  samp_d  = '0;
                  ovl_d   = 1'b0;
                  state_d = UNLOAD;
               end else begin
                  comp_d = comp_q + 8'd1;
               end
            end

            UNLOAD: begin
               if (ovl_q) begin
                  // Result and next-frame sample move together so the bank swap stays aligned.
                  m_valid = s_valid;
                  s_ready = m_ready;
                  advance = s_valid & m_ready;
               end else begin
                  m_valid = 1'b1;
                  advance = m_ready;
                  if (samp_q == '0) begin
                     s_ready = m_ready;
                     if (s_valid && m_ready) begin
                        core_start = 1'b1;
                        ovl_d      = 1'b1;
                     end
                  end
               end
               m_last     = m_valid & (samp_q == SAMP_LAST);
               core_valid = advance;
               if (advance) begin
                  if (samp_q == SAMP_LAST) begin
                     frame_d = frame_q + FRAME_CNT_W'(1);
                     samp_d  = '0;
                     comp_d  = '0;
                     ovl_d   = 1'b0;
                     state_d = ovl_q ? COMPUTE : IDLE;
                  end else begin
                     samp_d = samp_q + CNT_W'(1);
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end

      if (flush) begin
         core_start = 1'b0;
         core_valid = 1'b0;
         state_d    = IDLE;
         samp_d     = '0;
         comp_d     = '0;
         ovl_d      = 1'b0;
         frame_d    = frame_q;
      end
   end

   assign busy      = (state_q != IDLE);
   assign frame_cnt = frame_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         samp_q     <= '0;
         comp_q     <= '0;
         ovl_q      <= 1'b0;
         rst_done_q <= 1'b0;
         frame_q    <= '0;
      end else begin
         state_q    <= state_d;
         samp_q     <= samp_d;
         comp_q     <= comp_d;
         ovl_q      <= ovl_d;
         rst_done_q <= 1'b1;
         frame_q    <= frame_d;
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: streaming, idle source, bubbly load,
// sink stall with overlap, flush and mid-unload reset.
module tb_fft_frame_sequencer;

   logic        clk = 1'b0;
   logic        nrst, flush, s_valid, m_ready;
   logic        s_ready, m_valid, m_last, core_start, core_valid, busy;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cnt_start, cnt_acc, cnt_srdy, cnt_cv, cnt_mval, cnt_mhs, cnt_last;
   int mir_bad;

   fft_frame_sequencer dut (
      .clk        (clk),
      .nrst       (nrst),
      .flush      (flush),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .core_start (core_start),
      .core_valid (core_valid),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {s_ready, m_valid, m_last, core_start, core_valid, busy};
   endfunction

   task automatic settle();
      #4;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      cnt_start = 0; cnt_acc = 0; cnt_srdy = 0; cnt_cv = 0;
      cnt_mval = 0; cnt_mhs = 0; cnt_last = 0;
   endtask

   task automatic sample();
      if (core_start) cnt_start++;
      if (s_valid && s_ready) cnt_acc++;
      if (s_ready) cnt_srdy++;
      if (core_valid) cnt_cv++;
      if (m_valid) cnt_mval++;
      if (m_valid && m_ready) cnt_mhs++;
      if (m_last && m_valid && m_ready) cnt_last++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         sample();
         next();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "bench timeout");
   end

   initial begin
      nrst = 1'b0; flush = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
      clr();
      mir_bad = 0;

      // ---- 1: continuous streaming, overlap on next frame ----
      repeat (2) @(posedge clk);
      #1;
      settle();
      chk("rst_outs", 32'(outs()), 32'd0);
      chk("rst_frame", 32'(frame_cnt), 32'd0);
      next();
      nrst = 1'b1;
      settle();
      chk("rel_cyc0_outs", 32'(outs()), 32'd0);
      next();
      settle();
      chk("cyc1_start", 32'(core_start), 32'd1);
      chk("cyc1_cv", 32'(core_valid), 32'd1);
      next();
      clr();
      run(63);
      chk("t1_load_acc", 32'(cnt_acc), 32'd63);
      chk("t1_load_start", 32'(cnt_start), 32'd0);
      clr();
      run(192);
      chk("t1_comp_cv", 32'(cnt_cv), 32'd192);
      chk("t1_comp_srdy", 32'(cnt_srdy), 32'd0);
      chk("t1_comp_mval", 32'(cnt_mval), 32'd0);
      clr();
      run(63);
      chk("t1_unl_start", 32'(cnt_start), 32'd1);
      chk("t1_unl_mhs", 32'(cnt_mhs), 32'd63);
      chk("t1_unl_acc", 32'(cnt_acc), 32'd63);
      chk("t1_unl_last_early", 32'(cnt_last), 32'd0);
      settle();
      chk("t1_last_beat64", 32'(m_last & m_valid), 32'd1);
      next();
      settle();
      chk("t1_frame1", 32'(frame_cnt), 32'd1);
      chk("t1_ovl_busy", 32'(busy), 32'd1);
      chk("t1_ovl_srdy", 32'(s_ready), 32'd0);

      // ---- 2: source idle during unload ----
      next();
      s_valid = 1'b0;
      clr();
      run(191);
      chk("t2_comp_cv", 32'(cnt_cv), 32'd191);
      clr();
      run(64);
      chk("t2_unl_mhs", 32'(cnt_mhs), 32'd64);
      chk("t2_unl_srdy", 32'(cnt_srdy), 32'd1);
      chk("t2_unl_start", 32'(cnt_start), 32'd0);
      chk("t2_unl_last", 32'(cnt_last), 32'd1);
      settle();
      chk("t2_idle_busy", 32'(busy), 32'd0);
      chk("t2_frame2", 32'(frame_cnt), 32'd2);
      next();

      // ---- 3: load with s_valid toggling ----
      clr();
      for (int i = 0; i < 127; i++) begin
         s_valid = (i % 2 == 0);
         settle();
         if (core_valid !== s_valid) mir_bad++;
         sample();
         next();
      end
      s_valid = 1'b1;
      settle();
      chk("t3_mirror", 32'(mir_bad), 32'd0);
      chk("t3_acc", 32'(cnt_acc), 32'd64);
      chk("t3_start", 32'(cnt_start), 32'd1);
      chk("t3_in_comp_busy", 32'(busy), 32'd1);
      chk("t3_in_comp_srdy", 32'(s_ready), 32'd0);

      // ---- 4: overlapped unload with 5-cycle sink stall at samp_cnt 10 ----
      next();
      run(191);
      clr();
      run(10);
      chk("t4_pre_start", 32'(cnt_start), 32'd1);
      chk("t4_pre_mhs", 32'(cnt_mhs), 32'd10);
      m_ready = 1'b0;
      clr();
      run(5);
      chk("t4_stall_srdy", 32'(cnt_srdy), 32'd0);
      chk("t4_stall_cv", 32'(cnt_cv), 32'd0);
      chk("t4_stall_mhs", 32'(cnt_mhs), 32'd0);
      m_ready = 1'b1;
      clr();
      run(53);
      chk("t4_post_mhs", 32'(cnt_mhs), 32'd53);
      chk("t4_post_acc", 32'(cnt_acc), 32'd53);
      chk("t4_post_last_early", 32'(cnt_last), 32'd0);
      settle();
      chk("t4_last", 32'(m_last & m_valid), 32'd1);
      next();
      settle();
      chk("t4_frame3", 32'(frame_cnt), 32'd3);
      chk("t4_comp_busy", 32'(busy), 32'd1);

      // ---- 5: flush at comp_cnt 100 ----
      next();
      s_valid = 1'b0;
      run(99);
      flush = 1'b1;
      settle();
      chk("t5_flush_cv", 32'(core_valid), 32'd0);
      next();
      flush = 1'b0;
      settle();
      chk("t5_idle_busy", 32'(busy), 32'd0);
      chk("t5_frame_keep", 32'(frame_cnt), 32'd3);
      next();
      clr();
      run(20);
      chk("t5_no_mval", 32'(cnt_mval), 32'd0);

      // ---- 6: reset pulse mid-unload ----
      s_valid = 1'b1;
      run(64);
      run(192);
      run(29);
      settle();
      chk("t6_pre_mval", 32'(m_valid), 32'd1);
      #1;
      nrst = 1'b0;
      #1;
      chk("t6_rst_outs", 32'(outs()), 32'd0);
      chk("t6_rst_frame", 32'(frame_cnt), 32'd0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      settle();
      chk("t6_rel_outs", 32'(outs()), 32'd0);
      next();
      settle();
      chk("t6_srdy", 32'(s_ready), 32'd1);
      chk("t6_start", 32'(core_start), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
